adc_frame_sequencer: RTL and testbench
======================================

// Module: adc_frame_sequencer
// PURPOSE
//  Full-frame SPI master for the 8-channel 12-bit serial ADC (ADC128S022 protocol).
//  Drives CS_N/SCLK/DIN, shifts in the 16-bit DOUT frame, and scans channels round-robin.
//  Emits a tagged 12-bit sample with a one-cycle valid strobe to the PID/PWM stage downstream.
// PARAMETERS
//  CLKS_PER_HALF_BIT  8   i_Clk cycles per SCLK half-period (min 2; 8 -> 3.125 MHz at 50 MHz)
//  GAP_CLKS           16  i_Clk cycles CS_N held high between frames (min 1)
// PORTS
//  i_Clk         in   1   system clock (50 MHz)
//  i_Rst_L       in   1   synchronous reset, active low
//  i_Enable      in   1   1 = run frames continuously; 0 = stop after the current frame
//  i_Chan_Mask   in   8   bit k set = scan channel INk; 8'h00 is treated as 8'h01
//  o_ADC_CS_N    out  1   ADC chip select, active low
//  o_ADC_SCLK    out  1   ADC serial clock, idles high
//  o_ADC_DIN     out  1   ADC control serial data (MOSI)
//  i_ADC_DOUT    in   1   ADC serial data (MISO)
//  o_Sample      out  12  last converted value
//  o_Chan        out  3   channel that o_Sample belongs to
//  o_Sample_DV   out  1   one-cycle strobe; o_Sample and o_Chan are valid and held until the next strobe
//  o_Busy        out  1   1 while any state other than IDLE
// BEHAVIOUR
//  Reset values: CS_N=1, SCLK=1, DIN=0, o_Sample=0, o_Chan=0, DV=0, Busy=0.
//   State=IDLE, primed=0, cur_addr=0, prev_addr=0.
//  FSM: IDLE -> SETUP -> {LOW, HIGH} x16 -> HOLD -> GAP -> SETUP (or IDLE).
//   Every half-period state lasts CLKS_PER_HALF_BIT cycles.
//  IDLE: CS_N=1, SCLK=1. Leaves to SETUP when i_Enable=1.
//  SETUP entry (frame start):
//   - Latch the effective mask.
//   - Select next_addr = the next set mask bit strictly above cur_addr, ascending, wrapping 7->0.
//     If cur_addr is the only set bit, next_addr=cur_addr.
//   - prev_addr<=cur_addr, cur_addr<=next_addr.
//   - Control word = {2'b00, next_addr, 11'b0}, shifted MSB first.
//   - CS_N=0, SCLK=1, DIN=bit15.
//  LOW (bit n): SCLK=0. DIN updated to bit n on entry, so it changes only on SCLK falling edges.
//  HIGH (bit n): SCLK=1. On entry, i_ADC_DOUT is shifted in, MSB first, into a 16-bit register.
//   The ADC samples DIN on this rising edge. 16 rising edges per frame; 4-bit bit counter 0..15.
//  HOLD: SCLK=1, CS_N=0 for one half-period after the 16th rising edge.
//  GAP entry: CS_N=1, SCLK=1, DIN=0.
//   - If primed=1: o_Sample<=shift[11:0], o_Chan<=prev_addr, DV=1 for exactly this cycle.
//   - primed<=1 in all cases.
//   - After GAP_CLKS cycles: SETUP if i_Enable=1, else IDLE with primed<=0.
//  Timing:
//   - CS_N low for 34*CLKS_PER_HALF_BIT cycles (272 at default).
//   - Frame period is 34*CLKS_PER_HALF_BIT+GAP_CLKS (288 at default).
//   - DV lands in the same cycle CS_N rises.
//  Pipeline rule: the address sent in frame N selects the conversion returned in frame N+1.
//   The first frame after reset or after IDLE is a priming frame: no DV.
//  i_Enable sampled only in IDLE and at the end of GAP. Deassertion mid-frame completes the frame incl. DV.
//  Mask changes mid-frame take effect at the next SETUP entry.
//  Reset mid-frame: next cycle all outputs at reset values; the frame is abandoned, no DV.
// TESTING (ADC model: channel k returns 12'h0AB + 12'h100*k, 4 leading zeros; checks DIN addr)
//  1. Reset, enable, mask 8'h01.
//     -> No DV in frame 1; then DV every 288 clks, o_Chan=0, o_Sample=12'h0AB.
//  2. Mask 8'b1010_0100.
//     -> DIN addresses 2,5,7,2,...; DV tags (after priming) 2,5,7 with samples 12'h2AB, 12'h5AB, 12'h7AB.
//  3. Waveform check, default params.
//     -> CS_N low 272 clks; exactly 16 SCLK rises, each half 8 clks.
//     -> SCLK=1 whenever CS_N=1; DIN changes only on SCLK falling edges.
//  4. Drop i_Enable at bit 6 of frame 5.
//     -> Frame completes, DV with the correct sample, then IDLE (CS_N=1, Busy=0).
//     -> Re-enable: the first frame is a priming frame (no DV).
//  5. Assert i_Rst_L=0 for one cycle at bit 9.
//     -> Next cycle CS_N=1, SCLK=1, DV=0, o_Sample=0; the restarted run repeats scenario 1.
//  6. Mask 8'h00, then 8'h80 written mid-frame.
//     -> Channel 0 is scanned until the next SETUP, then only channel 7.

Source files
------------

// File: rtl/adc_frame_sequencer_if.sv
// adc_frame_sequencer_if: control, ADC serial pins and tagged-sample output of the frame sequencer.
interface adc_frame_sequencer_if;
    logic        i_Enable;
    logic [7:0]  i_Chan_Mask;
    logic        o_ADC_CS_N;
    logic        o_ADC_SCLK;
    logic        o_ADC_DIN;
    logic        i_ADC_DOUT;
    logic [11:0] o_Sample;
    logic [2:0]  o_Chan;
    logic        o_Sample_DV;
    logic        o_Busy;

    modport master (
        input  i_Enable, i_Chan_Mask, i_ADC_DOUT,
        output o_ADC_CS_N, o_ADC_SCLK, o_ADC_DIN, o_Sample, o_Chan, o_Sample_DV, o_Busy
    );

    modport slave (
        output i_Enable, i_Chan_Mask, i_ADC_DOUT,
        input  o_ADC_CS_N, o_ADC_SCLK, o_ADC_DIN, o_Sample, o_Chan, o_Sample_DV, o_Busy
    );
endinterface

// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer: ADC128S022 SPI frame master scanning masked channels round-robin.
module adc_frame_sequencer #(
    parameter int CLKS_PER_HALF_BIT = 8,
    parameter int GAP_CLKS          = 16
) (
    input logic                   i_Clk,
    input logic                   i_Rst_L,
    adc_frame_sequencer_if.master io_Bus
);
    localparam int MAXC = (CLKS_PER_HALF_BIT > GAP_CLKS) ? CLKS_PER_HALF_BIT : GAP_CLKS;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          w_last;
    logic [3:0]    r_bit, w_bit;
    logic [2:0]    r_cur, r_prev, w_next_addr, r_chan;
    logic [7:0]    w_mask;
    logic [15:0]   w_word;
    logic [11:0]   r_shift, r_sample;
    logic          r_cs_n, r_sclk, r_din, r_dv, r_primed;

    assign io_Bus.o_ADC_CS_N  = r_cs_n;
    assign io_Bus.o_ADC_SCLK  = r_sclk;
    assign io_Bus.o_ADC_DIN   = r_din;
    assign io_Bus.o_Sample    = r_sample;
    assign io_Bus.o_Chan      = r_chan;
    assign io_Bus.o_Sample_DV = r_dv;
    assign io_Bus.o_Busy      = r_state != IDLE;

    always_comb begin
        w_mask      = (io_Bus.i_Chan_Mask == 8'h00) ? 8'h01 : io_Bus.i_Chan_Mask;
        w_next_addr = r_cur;
        // descending walk so the nearest set bit above r_cur wins
        for (int i = 7; i >= 1; i--)
            if (w_mask[r_cur + 3'(i)]) w_next_addr = r_cur + 3'(i);
        w_word = {2'b00, r_cur, 11'b0};
        w_bit  = (r_state == SETUP) ? 4'd0 : r_bit + 4'd1;
        w_last = r_cnt == ((r_state == GAP) ? CW'(GAP_CLKS - 1) : CW'(CLKS_PER_HALF_BIT - 1));
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = io_Bus.i_Enable ? SETUP : IDLE;
            SETUP:   w_next = w_last ? LOW : SETUP;
            LOW:     w_next = w_last ? HIGH : LOW;
            HIGH:    w_next = w_last ? ((r_bit == 4'd15) ? HOLD : LOW) : HIGH;
            HOLD:    w_next = w_last ? GAP : HOLD;
            GAP:     w_next = w_last ? (io_Bus.i_Enable ? SETUP : IDLE) : GAP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_cur    <= '0;
            r_prev   <= '0;
            r_shift  <= '0;
            r_sample <= '0;
            r_chan   <= '0;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b1;
            r_din    <= 1'b0;
            r_dv     <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_dv  <= 1'b0;
            r_cnt <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 1'b1;
            if (w_next != r_state) begin
                case (w_next)
                    SETUP: begin
                        r_prev <= r_cur;
                        r_cur  <= w_next_addr;
                        r_cs_n <= 1'b0;
                        r_sclk <= 1'b1;
                        r_din  <= 1'b0;
                    end
                    LOW: begin
                        r_sclk <= 1'b0;
                        r_bit  <= w_bit;
                        r_din  <= w_word[~w_bit];
                    end
                    HIGH: begin
                        r_sclk  <= 1'b1;
                        r_shift <= {r_shift[10:0], io_Bus.i_ADC_DOUT};
                    end
                    GAP: begin
                        r_cs_n   <= 1'b1;
                        r_din    <= 1'b0;
                        r_primed <= 1'b1;
                        r_dv     <= r_primed;
                        if (r_primed) begin
                            r_sample <= r_shift;
                            r_chan   <= r_prev;
                        end
                    end
                    IDLE:    r_primed <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb_adc_frame_sequencer: ADC model, waveform monitor and tagged-sample scoreboard.
module tb_adc_frame_sequencer;
    localparam int HALF  = 8;
    localparam int GAPC  = 16;
    localparam int FRAME = 34 * HALF + GAPC;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;

    adc_frame_sequencer_if sif ();

    adc_frame_sequencer #(.CLKS_PER_HALF_BIT(HALF), .GAP_CLKS(GAPC)) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_l),
        .io_Bus (sif)
    );

    always #10 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int n_dv = 0, n_frames = 0, cyc = 0, prev_dv = 0;
    int rises = 0, falls = 0, cs_len = 0, run = 1;
    int viol_sclk = 0, viol_din = 0, viol_half = 0;
    logic        abort = 1'b0;
    logic        p_cs = 1'b1, p_sclk = 1'b1, p_din = 1'b0, p_busy = 1'b0;
    logic [7:0]  p_mask = 8'h01;
    logic [15:0] din_word = '0, adc_frame = '0;
    logic [2:0]  m_cur = '0, exp_addr = '0, last_sent = '0;
    logic [14:0] e;
    logic [14:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] mask);
        logic [7:0] m;
        logic [2:0] idx;
        m = (mask == 8'h00) ? 8'h01 : mask;
        for (int k = 1; k <= 8; k++) begin
            idx = 3'(cur + 3'(k));
            if (m[idx]) return idx;
        end
        return cur;
    endfunction

    function automatic logic [11:0] adc_val(input logic [2:0] k);
        return 12'h0AB + 12'h100 * {9'd0, k};
    endfunction

    // ADC model plus protocol monitor, all evaluated mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (!rst_l) begin
            if (!sif.o_ADC_CS_N) abort = 1'b1;
            m_cur = '0;
            sif.i_ADC_DOUT = 1'b0;
        end
        if (sif.o_Sample_DV) begin
            n_dv++;
            check("dv_at_cs_rise", {p_cs, sif.o_ADC_CS_N}, 2'b01);
            if (prev_dv != 0) check("dv_period", cyc - prev_dv, FRAME);
            prev_dv = cyc;
            if (sb.size() == 0) check("dv_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                check("dv_chan", sif.o_Chan, e[14:12]);
                check("dv_sample", sif.o_Sample, e[11:0]);
            end
        end
        if (p_busy && !sif.o_Busy) begin
            sb.delete();
            prev_dv = 0;
        end
        if (sif.o_ADC_CS_N && !sif.o_ADC_SCLK) viol_sclk++;
        if (sif.o_ADC_DIN != p_din && !(p_sclk && !sif.o_ADC_SCLK) && !abort) viol_din++;
        if (p_cs && !sif.o_ADC_CS_N) begin
            exp_addr  = next_ch(m_cur, p_mask);
            m_cur     = exp_addr;
            rises     = 0;
            falls     = 0;
            cs_len    = 0;
            din_word  = '0;
            adc_frame = {4'h0, adc_val(last_sent)};
        end
        if (!sif.o_ADC_CS_N) cs_len++;
        if (sif.o_ADC_SCLK != p_sclk && !p_cs && !sif.o_ADC_CS_N) begin
            if (run != HALF && !abort) viol_half++;
            if (!sif.o_ADC_SCLK) begin
                if (falls < 16) sif.i_ADC_DOUT = adc_frame[15 - falls];
                falls++;
            end else begin
                din_word = {din_word[14:0], sif.o_ADC_DIN};
                rises++;
            end
        end
        if (!p_cs && sif.o_ADC_CS_N) begin
            if (!abort) begin
                check("cs_low_len", cs_len, 34 * HALF);
                check("sclk_rises", rises, 16);
                check("hold_len", run, 2 * HALF);
                check("din_word", din_word, {2'b00, exp_addr, 11'b0});
                last_sent = din_word[13:11];
                sb.push_back({exp_addr, adc_val(exp_addr)});
                n_frames++;
            end
            abort = 1'b0;
        end
        run    = (sif.o_ADC_SCLK != p_sclk || sif.o_ADC_CS_N != p_cs) ? 1 : run + 1;
        p_cs   = sif.o_ADC_CS_N;
        p_sclk = sif.o_ADC_SCLK;
        p_din  = sif.o_ADC_DIN;
        p_busy = sif.o_Busy;
        p_mask = sif.i_Chan_Mask;
    end

    task automatic wait_dv(input int target, input int budget);
        int c = 0;
        while (n_dv < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("dv_count", n_dv, target);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int c = 0;
        while (n_frames < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("frame_count", n_frames, target);
    endtask

    task automatic wait_bit(input int n, input int budget);
        int c = 0;
        while ((sif.o_ADC_CS_N || rises != n) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("bit_reached", rises, n);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (sif.o_Busy && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("went_idle", sif.o_Busy, 0);
    endtask

    initial begin
        int d0, f0;
        sif.i_Enable    = 1'b0;
        sif.i_Chan_Mask = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", sif.o_ADC_CS_N, 1);
        check("rst_sclk", sif.o_ADC_SCLK, 1);
        check("rst_din", sif.o_ADC_DIN, 0);
        check("rst_sample", sif.o_Sample, 0);
        check("rst_chan", sif.o_Chan, 0);
        check("rst_dv", sif.o_Sample_DV, 0);
        check("rst_busy", sif.o_Busy, 0);

        // single channel 0, first frame primes the pipeline
        rst_l        = 1'b1;
        sif.i_Enable = 1'b1;
        wait_dv(1, 3 * FRAME);
        check("prime_frames", n_frames, 2);
        wait_dv(4, 4 * FRAME);

        // sparse mask 2,5,7
        sif.i_Chan_Mask = 8'b1010_0100;
        wait_dv(n_dv + 7, 9 * FRAME);

        // stop mid-frame: frame finishes with its sample, then idle
        wait_bit(6, 2 * FRAME);
        sif.i_Enable = 1'b0;
        d0 = n_dv;
        wait_idle(2 * FRAME);
        check("dv_on_stop", n_dv - d0, 1);
        check("idle_cs_n", sif.o_ADC_CS_N, 1);
        repeat (100) @(posedge clk);
        #1;
        check("stay_idle", sif.o_Busy, 0);
        f0 = n_frames;
        d0 = n_dv;
        sif.i_Enable = 1'b1;
        wait_frames(f0 + 2, 3 * FRAME);
        check("reprime_dv", n_dv - d0, 1);

        // one-cycle reset at bit 9 abandons the frame
        sif.i_Chan_Mask = 8'h01;
        wait_bit(9, 2 * FRAME);
        rst_l = 1'b0;
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        check("mid_rst_cs_n", sif.o_ADC_CS_N, 1);
        check("mid_rst_sclk", sif.o_ADC_SCLK, 1);
        check("mid_rst_dv", sif.o_Sample_DV, 0);
        check("mid_rst_sample", sif.o_Sample, 0);
        check("mid_rst_busy", sif.o_Busy, 0);
        f0 = n_frames;
        d0 = n_dv;
        wait_dv(d0 + 1, 3 * FRAME);
        check("reset_prime", n_frames - f0, 2);
        wait_dv(d0 + 3, 3 * FRAME);

        // empty mask falls back to channel 0, then 0x80 written mid-frame
        sif.i_Chan_Mask = 8'h00;
        wait_dv(n_dv + 2, 3 * FRAME);
        wait_bit(5, 2 * FRAME);
        sif.i_Chan_Mask = 8'h80;
        wait_dv(n_dv + 4, 5 * FRAME);
        check("last_chan", sif.o_Chan, 7);
        check("last_sample", sif.o_Sample, 12'h7AB);

        check("sclk_high_when_cs_high", viol_sclk, 0);
        check("din_only_on_sclk_fall", viol_din, 0);
        check("half_period_len", viol_half, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
